// File: rtl/rv_pkg.sv
// Shared RV pipeline constants: data width, register address width, write-back source selects.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RF_SEL_ALU  = 2'b00,
      RF_SEL_LOAD = 2'b01,
      RF_SEL_PC4  = 2'b10,
      RF_SEL_NONE = 2'b11
   } rf_sel_e;

endpackage

// File: rtl/wb_select.sv
// Write-back source mux: picks ALU, load or link value; the reserved select yields zero and no write.
module wb_select
   import rv_pkg::*;
#(
   parameter int WIDTH = rv_pkg::XLEN
) (
   input  logic [1:0]       controlRF,
   input  logic [WIDTH-1:0] result,
   input  logic [WIDTH-1:0] loadData,
   input  logic [WIDTH-1:0] sum_out,
   output logic [WIDTH-1:0] wb_data,
   output logic             sel_valid
);

   always_comb begin
      wb_data   = '0;
      sel_valid = 1'b1;
      case (rf_sel_e'(controlRF))
         RF_SEL_ALU:  wb_data = result;
         RF_SEL_LOAD: wb_data = loadData;
         RF_SEL_PC4:  wb_data = sum_out;
         default:     sel_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 integer register file with two async read ports and a commit counter.
// Define WB_BYPASS_EN for write-first reads (same-cycle write data forwarded to matching read ports).
module wb_regfile
   import rv_pkg::*;
#(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int NREGS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [XLEN-1:0]       loadData,
   input  logic [XLEN-1:0]       sum_out,
   input  logic [XLEN-1:0]       result,
   input  logic [1:0]            controlRF,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic [31:0]           wb_count
);

   logic [XLEN-1:0] regs [NREGS];
   logic [31:0]     cnt_q;
   logic            sel_valid;
   logic            wen;

   wb_select #(.WIDTH(XLEN)) u_wb_select (
      .controlRF (controlRF),
      .result    (result),
      .loadData  (loadData),
      .sum_out   (sum_out),
      .wb_data   (wb_data),
      .sel_valid (sel_valid)
   );

   assign wen      = we & sel_valid & (rd != '0);
   assign wb_valid = wen;
   assign wb_rd    = rd;
   assign wb_count = cnt_q;

   // Reset wins over a coincident write; x0 is only ever cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         cnt_q <= '0;
      end else if (wen) begin
         regs[rd] <= wb_data;
         cnt_q    <= cnt_q + 32'd1;
      end
   end

   always_comb begin
      rs1_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs[rs1_addr];
`ifdef WB_BYPASS_EN
         if (wen && (rs1_addr == rd)) rs1_data = wb_data;
`endif
      end
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr != '0) begin
         rs2_data = regs[rs2_addr];
`ifdef WB_BYPASS_EN
         if (wen && (rs2_addr == rd)) rs2_data = wb_data;
`endif
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver queues expected outputs each cycle, monitor checks them at negedge.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] loadData, sum_out, result;
   logic [1:0]  controlRF;
   logic        we;
   logic [4:0]  rd, rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data, wb_count;
   logic        wb_valid;
   logic [4:0]  wb_rd;

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   typedef enum int {S_RS1, S_RS2, S_VALID, S_RD, S_DATA, S_COUNT} sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .loadData  (loadData),
      .sum_out   (sum_out),
      .result    (result),
      .controlRF (controlRF),
      .we        (we),
      .rd        (rd),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_count  (wb_count)
   );

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic expect_sig(input string name, input sig_e sig, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   // Advance to just after the next posedge and present new inputs.
   task automatic drive(input logic r, input logic w, input logic [1:0] sel, input logic [4:0] d,
                        input logic [31:0] res, input logic [31:0] ld, input logic [31:0] pc4,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(posedge clk);
      #1;
      rst = r; we = w; controlRF = sel; rd = d;
      result = res; loadData = ld; sum_out = pc4;
      rs1_addr = a1; rs2_addr = a2;
   endtask

   // Monitor: every negedge, drain what the driver queued for this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.sig)
            S_RS1:   act = rs1_data;
            S_RS2:   act = rs2_data;
            S_VALID: act = {31'd0, wb_valid};
            S_RD:    act = {27'd0, wb_rd};
            S_DATA:  act = wb_data;
            default: act = wb_count;
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
         end
      end
   end

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL watchdog: got timeout expected completion");
         $fatal(1, "watchdog expired");
      end
   end

   initial begin
      rst = 1'b1; we = 1'b0; controlRF = 2'b00; rd = 5'd0;
      result = '0; loadData = '0; sum_out = '0; rs1_addr = 5'd0; rs2_addr = 5'd0;

      drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);

      // Reset state: every address reads zero, counter zero, idle wb outputs.
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 2'b00, 0, 0, 0, 0, 5'(i), 5'(31 - i));
         expect_sig("reset_rs1", S_RS1, 32'd0);
         expect_sig("reset_rs2", S_RS2, 32'd0);
         if (i == 0) begin
            expect_sig("reset_count", S_COUNT, 32'd0);
            expect_sig("reset_valid", S_VALID, 32'd0);
            expect_sig("reset_data", S_DATA, 32'd0);
         end
      end

      // ALU write to x5, read same cycle then next cycle.
      drive(0, 1, 2'b00, 5, 32'hDEADBEEF, 32'h1, 32'h2, 5, 0);
      expect_sig("x5_valid", S_VALID, 32'd1);
      expect_sig("x5_rd", S_RD, 32'd5);
      expect_sig("x5_data", S_DATA, 32'hDEADBEEF);
      expect_sig("x5_same_cycle", S_RS1, BYP ? 32'hDEADBEEF : 32'd0);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 5, 0);
      expect_sig("x5_read", S_RS1, 32'hDEADBEEF);
      expect_sig("count_1", S_COUNT, 32'd1);

      // Write to x0 is suppressed and uncounted.
      drive(0, 1, 2'b01, 0, 0, 32'h1234, 0, 0, 0);
      expect_sig("x0_valid", S_VALID, 32'd0);
      expect_sig("x0_data", S_DATA, 32'h1234);
      expect_sig("x0_same_read", S_RS1, 32'd0);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      expect_sig("x0_read", S_RS1, 32'd0);
      expect_sig("x0_count", S_COUNT, 32'd1);

      // Load write to x7, then reserved select must not overwrite it.
      drive(0, 1, 2'b01, 7, 32'hFFFF, 32'h77, 32'hEEEE, 0, 0);
      expect_sig("x7_load_data", S_DATA, 32'h77);
      drive(0, 1, 2'b11, 7, 32'hFFFF, 32'hAAAA, 32'hBBBB, 7, 0);
      expect_sig("sel11_valid", S_VALID, 32'd0);
      expect_sig("sel11_data", S_DATA, 32'd0);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 7, 0);
      expect_sig("x7_kept", S_RS1, 32'h77);
      expect_sig("count_2", S_COUNT, 32'd2);

      // Link write to x3, then same-cycle overwrite seen on both ports.
      drive(0, 1, 2'b10, 3, 32'h0, 32'h0, 32'h11111111, 0, 0);
      expect_sig("x3_pc4_data", S_DATA, 32'h11111111);
      drive(0, 1, 2'b00, 3, 32'hA5A5A5A5, 0, 0, 3, 3);
      expect_sig("x3_byp_rs1", S_RS1, BYP ? 32'hA5A5A5A5 : 32'h11111111);
      expect_sig("x3_byp_rs2", S_RS2, BYP ? 32'hA5A5A5A5 : 32'h11111111);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 3, 3);
      expect_sig("x3_next_rs1", S_RS1, 32'hA5A5A5A5);
      expect_sig("x3_next_rs2", S_RS2, 32'hA5A5A5A5);
      expect_sig("count_4", S_COUNT, 32'd4);

      // Counter wrap: preload all-ones, one more write wraps to zero.
      @(posedge clk);
      #1;
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      rst = 0; we = 1; controlRF = 2'b00; rd = 5'd10; result = 32'h1;
      loadData = '0; sum_out = '0; rs1_addr = 5'd0; rs2_addr = 5'd0;
      expect_sig("count_preload", S_COUNT, 32'hFFFF_FFFF);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 10, 0);
      expect_sig("count_wrap", S_COUNT, 32'd0);
      expect_sig("x10_read", S_RS1, 32'd1);

      // Reset coincident with a write to x9 drops the write.
      drive(0, 1, 2'b00, 9, 32'h99, 0, 0, 0, 0);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 9, 0);
      expect_sig("x9_pre", S_RS1, 32'h99);
      drive(1, 1, 2'b00, 9, 32'hBAD, 0, 0, 0, 0);
      drive(0, 0, 2'b00, 0, 0, 0, 0, 9, 10);
      expect_sig("x9_after_rst", S_RS1, 32'd0);
      expect_sig("x10_after_rst", S_RS2, 32'd0);
      expect_sig("count_after_rst", S_COUNT, 32'd0);

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
